// File: rtl/video_pixel_sequencer.sv
// rtl/video_pixel_sequencer.sv - scanline pixel sequencer: word fetch, one-word prefetch, per-bpp pixel index stepping
module video_pixel_sequencer #(
    parameter int PIX_CNT_W = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           bpp_log,
    input  logic [PIX_CNT_W-1:0] line_pixels,
    input  logic                 line_start,
    input  logic [31:0]          word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic                 pix_adv,
    output logic [31:0]          pixword,
    output logic [4:0]           x_index,
    output logic                 pix_valid,
    output logic                 line_done,
    output logic                 underflow
);

    localparam int CW = PIX_CNT_W + 1;
    localparam logic [PIX_CNT_W-1:0] PIX_ONE  = 1;
    localparam logic [CW-1:0]        WORD_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           bpp_q, bpp_d;
    logic [PIX_CNT_W-1:0] pix_left_q, pix_left_d;
    logic [CW-1:0]        words_left_q, words_left_d;
    logic [31:0]          pixword_q, pixword_d;
    logic [31:0]          nxt_word_q, nxt_word_d;
    logic                 nxt_full_q, nxt_full_d;
    logic [4:0]           x_q, x_d;
    logic                 started_q, started_d;
    logic                 line_done_q, line_done_d;
    logic                 underflow_q, underflow_d;

    logic [2:0]    bpp_in;
    logic [5:0]    ppw_in;
    logic [CW-1:0] words_to_fetch;
    logic [4:0]    last_idx;
    logic          at_last;
    logic          pix_take;
    logic          consume;
    logic          accept;

    assign bpp_in         = (bpp_log > 3'd4) ? 3'd4 : bpp_log;
    assign ppw_in         = 6'd32 >> bpp_in;
    assign words_to_fetch = ({1'b0, line_pixels} + CW'(ppw_in - 6'd1)) >> (3'd5 - bpp_in);
    assign last_idx       = 5'((6'd32 >> bpp_q) - 6'd1);
    assign at_last        = (x_q == last_idx);
    assign pix_take       = (state_q == S_ACTIVE) && pix_adv && !line_start;
    // The prefetch slot frees up in the same cycle its word moves into pixword.
    assign consume        = pix_take && (pix_left_q != PIX_ONE) && at_last;
    assign word_ready     = reset_n && (state_q != S_IDLE) && !line_start &&
                            (words_left_q != '0) && (!nxt_full_q || consume);
    assign accept         = word_ready && word_valid;

    always_comb begin
        state_d      = state_q;
        bpp_d        = bpp_q;
        pix_left_d   = pix_left_q;
        words_left_d = words_left_q;
        pixword_d    = pixword_q;
        nxt_word_d   = nxt_word_q;
        nxt_full_d   = nxt_full_q;
        x_d          = x_q;
        started_d    = started_q;
        line_done_d  = 1'b0;
        underflow_d  = 1'b0;
        if (line_start) begin
            bpp_d        = bpp_in;
            pix_left_d   = line_pixels;
            words_left_d = words_to_fetch;
            pixword_d    = '0;
            nxt_full_d   = 1'b0;
            x_d          = '0;
            started_d    = 1'b0;
            if (line_pixels == '0) begin
                state_d     = S_IDLE;
                line_done_d = 1'b1;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            if (accept) begin
                words_left_d = words_left_q - WORD_ONE;
            end
            case (state_q)
                S_FETCH: begin
                    if (pix_adv && started_q) begin
                        underflow_d = 1'b1;
                    end
                    if (accept) begin
                        pixword_d = word_in;
                        x_d       = '0;
                        state_d   = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (pix_take) begin
                        started_d  = 1'b1;
                        pix_left_d = pix_left_q - PIX_ONE;
                        if (pix_left_q == PIX_ONE) begin
                            state_d     = S_IDLE;
                            nxt_full_d  = 1'b0;
                            line_done_d = 1'b1;
                        end else if (!at_last) begin
                            x_d = x_q + 5'd1;
                            if (accept) begin
                                nxt_word_d = word_in;
                                nxt_full_d = 1'b1;
                            end
                        end else begin
                            x_d = '0;
                            if (nxt_full_q) begin
                                pixword_d  = nxt_word_q;
                                nxt_word_d = word_in;
                                nxt_full_d = accept;
                            end else if (accept) begin
                                pixword_d = word_in;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    end else if (accept) begin
                        nxt_word_d = word_in;
                        nxt_full_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            bpp_q        <= '0;
            pix_left_q   <= '0;
            words_left_q <= '0;
            pixword_q    <= '0;
            nxt_word_q   <= '0;
            nxt_full_q   <= 1'b0;
            x_q          <= '0;
            started_q    <= 1'b0;
            line_done_q  <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bpp_q        <= bpp_d;
            pix_left_q   <= pix_left_d;
            words_left_q <= words_left_d;
            pixword_q    <= pixword_d;
            nxt_word_q   <= nxt_word_d;
            nxt_full_q   <= nxt_full_d;
            x_q          <= x_d;
            started_q    <= started_d;
            line_done_q  <= line_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pixword   = pixword_q;
    assign x_index   = x_q;
    assign pix_valid = (state_q == S_ACTIVE);
    assign line_done = line_done_q;
    assign underflow = underflow_q;

endmodule
